// File: rtl/stopwatch_pkg.sv
// Shared types for the cascaded BCD stopwatch.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } sw_state_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with its own modulus, up/down stepping, saturating preset load.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  bcd_t i_ld_val,
  input  logic i_en,
  input  logic i_up,
  input  bcd_t i_max,
  output bcd_t o_val,
  output logic o_term
);

  bcd_t val_q, val_d;

  // Next digit value: clear beats load beats step; out-of-range presets clamp to max.
  always_comb begin
    val_d = val_q;
    if (i_clr) begin
      val_d = '0;
    end else if (i_load) begin
      val_d = (i_ld_val > i_max) ? i_max : i_ld_val;
    end else if (i_en) begin
      if (i_up) val_d = (val_q == i_max) ? '0 : val_q + 4'd1;
      else      val_d = (val_q == '0)    ? i_max : val_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) val_q <= '0;
    else          val_q <= val_d;
  end

  assign o_val  = val_q;
  // Terminal in the current direction: this digit rolls over on its next step.
  assign o_term = i_up ? (val_q == i_max) : (val_q == '0);

endmodule

// File: rtl/stopwatch_cascade_n.sv
// Cascaded BCD stopwatch / countdown timer: prescaler, run-control FSM,
// digit cascade, lap-hold snapshot and registered display mux.
module stopwatch_cascade_n
  import stopwatch_pkg::*;
#(
  parameter int                        DVSR         = 10_000_000,
  parameter int                        NUM_DIGITS   = 4,
  parameter logic [NUM_DIGITS*4-1:0]   DIGIT_MAX    = {4'd9, 4'd5, 4'd9, 4'd9},
  parameter bit                        STOP_AT_ZERO = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic                    i_clr,
  input  logic                    i_up,
  input  logic                    i_load,
  input  logic [NUM_DIGITS*4-1:0] i_preset,
  input  logic                    i_lap,
  output logic [NUM_DIGITS*4-1:0] o_digits,
  output logic                    o_running,
  output logic                    o_lap_held,
  output logic                    o_wrap,
  output logic                    o_done
);

  localparam int            PW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DVSR - 1);

  sw_state_t                   st_q, st_d;
  logic [PW-1:0]               presc_q, presc_d;
  logic                        lap_held_q, lap_held_d;
  logic [NUM_DIGITS*4-1:0]     lap_q, lap_d;
  logic                        wrap_q, wrap_d;

  logic [NUM_DIGITS-1:0][3:0]  live;
  logic [NUM_DIGITS-1:0]       term;
  logic [NUM_DIGITS-1:0]       en;

  logic in_run, load_eff, tick, all_zero, zero_hold, cnt_en;

  assign in_run    = (st_q == RUN);
  // Load is ignored while running; clear outranks it.
  assign load_eff  = i_load & ~i_clr & ~in_run;
  // Stop outranks the tick in the same cycle, so a paused count never advances.
  assign tick      = in_run & ~i_clr & ~i_stop & (presc_q == PMAX);
  assign all_zero  = (live == '0);
  // Down count parked at zero: nothing moves and start is refused.
  assign zero_hold = STOP_AT_ZERO & ~i_up & all_zero;
  assign cnt_en    = tick & ~zero_hold;

  // Digit cascade: digit k steps when every lower digit is terminal.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    if (k == 0) begin : g_lsd
      assign en[k] = cnt_en;
    end else begin : g_upper
      assign en[k] = cnt_en & (&term[k-1:0]);
    end
    bcd_digit_counter u_dig (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (i_clr),
      .i_load   (load_eff),
      .i_ld_val (i_preset[k*4 +: 4]),
      .i_en     (en[k]),
      .i_up     (i_up),
      .i_max    (DIGIT_MAX[k*4 +: 4]),
      .o_val    (live[k]),
      .o_term   (term[k])
    );
  end

  // Run-control FSM, priority clr > load > stop > start > tick.
  always_comb begin
    st_d = st_q;
    if (i_clr) begin
      st_d = IDLE;
    end else if (load_eff) begin
      st_d = PAUSED;
    end else if (i_stop) begin
      if (in_run) st_d = PAUSED;
    end else if (i_start) begin
      if ((st_q == IDLE || st_q == PAUSED) && !zero_hold) st_d = RUN;
    end else if (tick && zero_hold) begin
      st_d = DONE;
    end
  end

  // Prescaler advances only while running; held across pauses.
  always_comb begin
    presc_d = presc_q;
    if (i_clr || load_eff)     presc_d = '0;
    else if (in_run && !i_stop) presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
  end

  // Lap hold: snapshot in RUN, toggle release anywhere; clr and load release.
  always_comb begin
    lap_d      = lap_q;
    lap_held_d = lap_held_q;
    if (i_clr || load_eff) begin
      lap_held_d = 1'b0;
    end else if (i_lap) begin
      if (lap_held_q) begin
        lap_held_d = 1'b0;
      end else if (in_run) begin
        lap_held_d = 1'b1;
        lap_d      = live;
      end
    end
  end

  // Wrap flag lines up with the digit update it describes.
  always_comb begin
    wrap_d = cnt_en & (&term);
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st_q       <= IDLE;
      presc_q    <= '0;
      lap_q      <= '0;
      lap_held_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      presc_q    <= presc_d;
      lap_q      <= lap_d;
      lap_held_q <= lap_held_d;
      wrap_q     <= wrap_d;
    end
  end

  assign o_digits   = lap_held_q ? lap_q : live;
  assign o_running  = (st_q == RUN);
  assign o_done     = (st_q == DONE);
  assign o_lap_held = lap_held_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_cascade_n.sv
// Directed bench for stopwatch_cascade_n (DVSR=4, digits {9,5,9,9}).
// Inputs are driven and outputs sampled on the falling edge.
module tb_stopwatch_cascade_n;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, clr, up, load, lap;
  logic [15:0] preset;

  logic [15:0] dig, dig_w;
  logic        run, held, wrap, done;
  logic        run_w, held_w, wrap_w, done_w;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  stopwatch_cascade_n #(.DVSR(4), .NUM_DIGITS(4), .DIGIT_MAX({4'd9, 4'd5, 4'd9, 4'd9}),
                        .STOP_AT_ZERO(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_clr(clr),
    .i_up(up), .i_load(load), .i_preset(preset), .i_lap(lap),
    .o_digits(dig), .o_running(run), .o_lap_held(held), .o_wrap(wrap), .o_done(done));

  // Wrapping variant for the zero-crossing down count.
  stopwatch_cascade_n #(.DVSR(4), .NUM_DIGITS(4), .DIGIT_MAX({4'd9, 4'd5, 4'd9, 4'd9}),
                        .STOP_AT_ZERO(1'b0)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_clr(clr),
    .i_up(up), .i_load(load), .i_preset(preset), .i_lap(lap),
    .o_digits(dig_w), .o_running(run_w), .o_lap_held(held_w), .o_wrap(wrap_w), .o_done(done_w));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start; start = 1'b1; cyc(1); start = 1'b0; endtask
  task automatic do_stop;  stop  = 1'b1; cyc(1); stop  = 1'b0; endtask
  task automatic do_clr;   clr   = 1'b1; cyc(1); clr   = 1'b0; endtask
  task automatic do_lap;   lap   = 1'b1; cyc(1); lap   = 1'b0; endtask
  task automatic do_load(input logic [15:0] v);
    preset = v; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; stop = 0; clr = 0; up = 1'b1; load = 0; lap = 0; preset = '0;
    cyc(3);
    checks++; if ({dig, run, held, wrap, done} !== 20'h0) begin
      fails++; $display("FAIL reset_outputs got=%h/%b%b%b%b exp=0000/0000", dig, run, held, wrap, done);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  // 600 ticks roll the {9,5,9,9} cascade exactly to 1000.
  task automatic test_count_up;
    up = 1'b1;
    do_start;
    cyc(3);
    checks++; if (dig !== 16'h0000) begin fails++; $display("FAIL up_before_first_tick got=%h exp=0000", dig); end
    cyc(1);
    checks++; if (dig !== 16'h0001) begin fails++; $display("FAIL up_first_tick got=%h exp=0001", dig); end
    cyc(2395);
    checks++; if (dig !== 16'h0599) begin fails++; $display("FAIL up_599 got=%h exp=0599", dig); end
    cyc(1);
    checks++; if (dig !== 16'h1000) begin fails++; $display("FAIL up_600 got=%h exp=1000", dig); end
    checks++; if (run !== 1'b1) begin fails++; $display("FAIL up_running got=%b exp=1", run); end
  endtask

  task automatic test_wrap_up;
    do_clr;
    do_load(16'h9599);
    up = 1'b1;
    do_start;
    cyc(3);
    checks++; if (dig !== 16'h9599 || wrap !== 1'b0) begin
      fails++; $display("FAIL wrap_up_pre got=%h/%b exp=9599/0", dig, wrap);
    end
    cyc(1);
    checks++; if (dig !== 16'h0000 || wrap !== 1'b1) begin
      fails++; $display("FAIL wrap_up_edge got=%h/%b exp=0000/1", dig, wrap);
    end
    cyc(1);
    checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL wrap_up_pulse_len got=%b exp=0", wrap); end
  endtask

  task automatic test_countdown_done;
    do_clr;
    do_load(16'h0002);
    up = 1'b0;
    do_start;
    cyc(4);
    checks++; if (dig !== 16'h0001) begin fails++; $display("FAIL down_1 got=%h exp=0001", dig); end
    cyc(4);
    checks++; if (dig !== 16'h0000 || run !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL down_0 got=%h run=%b done=%b exp=0000 1 0", dig, run, done);
    end
    cyc(4);
    checks++; if (dig !== 16'h0000 || run !== 1'b0 || done !== 1'b1 || wrap !== 1'b0) begin
      fails++; $display("FAIL down_done got=%h run=%b done=%b wrap=%b exp=0000 0 1 0", dig, run, done, wrap);
    end
    cyc(8);
    checks++; if (dig !== 16'h0000 || done !== 1'b1) begin
      fails++; $display("FAIL down_done_hold got=%h done=%b exp=0000 1", dig, done);
    end
    // DONE -load-> PAUSED, with out-of-range nibbles clamped to each digit max.
    do_load(16'h97CB);
    checks++; if (dig !== 16'h9599 || done !== 1'b0 || run !== 1'b0) begin
      fails++; $display("FAIL load_saturate got=%h done=%b run=%b exp=9599 0 0", dig, done, run);
    end
    do_clr;
    up = 1'b0;
    do_start;
    checks++; if (run !== 1'b0) begin fails++; $display("FAIL start_at_zero_down got=%b exp=0", run); end
  endtask

  task automatic test_wrap_down;
    do_clr;
    do_load(16'h0000);
    up = 1'b0;
    do_start;
    checks++; if (run !== 1'b0 || run_w !== 1'b1) begin
      fails++; $display("FAIL wrapdown_start got=%b/%b exp=0/1", run, run_w);
    end
    cyc(3);
    checks++; if (dig_w !== 16'h0000 || wrap_w !== 1'b0) begin
      fails++; $display("FAIL wrapdown_pre got=%h/%b exp=0000/0", dig_w, wrap_w);
    end
    cyc(1);
    checks++; if (dig_w !== 16'h9599 || wrap_w !== 1'b1) begin
      fails++; $display("FAIL wrapdown_edge got=%h/%b exp=9599/1", dig_w, wrap_w);
    end
    cyc(1);
    checks++; if (dig_w !== 16'h9599 || wrap_w !== 1'b0) begin
      fails++; $display("FAIL wrapdown_after got=%h/%b exp=9599/0", dig_w, wrap_w);
    end
  endtask

  task automatic test_lap;
    do_clr;
    up = 1'b1;
    do_start;
    cyc(48);
    checks++; if (dig !== 16'h0012) begin fails++; $display("FAIL lap_pre got=%h exp=0012", dig); end
    do_lap;
    checks++; if (held !== 1'b1 || dig !== 16'h0012) begin
      fails++; $display("FAIL lap_take got=%b/%h exp=1/0012", held, dig);
    end
    cyc(12);
    checks++; if (dig !== 16'h0012 || run !== 1'b1) begin
      fails++; $display("FAIL lap_frozen got=%h run=%b exp=0012 1", dig, run);
    end
    do_lap;
    checks++; if (held !== 1'b0 || dig !== 16'h0015) begin
      fails++; $display("FAIL lap_release got=%b/%h exp=0/0015", held, dig);
    end
    cyc(2);
    checks++; if (dig !== 16'h0016) begin fails++; $display("FAIL lap_live got=%h exp=0016", dig); end
    // Direction change takes effect on the next tick.
    up = 1'b0;
    cyc(4);
    checks++; if (dig !== 16'h0015) begin fails++; $display("FAIL dir_change got=%h exp=0015", dig); end
  endtask

  // Continues from test_lap: just past a tick, prescaler at 0, counting down.
  task automatic test_stop_resume;
    cyc(2);
    do_stop;
    checks++; if (run !== 1'b0) begin fails++; $display("FAIL stop_paused got=%b exp=0", run); end
    cyc(50);
    checks++; if (dig !== 16'h0015) begin fails++; $display("FAIL pause_hold got=%h exp=0015", dig); end
    do_start;
    cyc(1);
    checks++; if (dig !== 16'h0015) begin fails++; $display("FAIL resume_early got=%h exp=0015", dig); end
    cyc(1);
    checks++; if (dig !== 16'h0014) begin fails++; $display("FAIL resume_tick got=%h exp=0014", dig); end
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    checks++; if (run !== 1'b0) begin fails++; $display("FAIL start_stop_same got=%b exp=0", run); end
    cyc(8);
    checks++; if (dig !== 16'h0014) begin fails++; $display("FAIL start_stop_hold got=%h exp=0014", dig); end
  endtask

  task automatic test_clr_reset;
    do_clr;
    up = 1'b1;
    do_start;
    do_load(16'h1234);
    checks++; if (dig !== 16'h0000 || run !== 1'b1) begin
      fails++; $display("FAIL load_in_run got=%h run=%b exp=0000 1", dig, run);
    end
    cyc(3);
    checks++; if (dig !== 16'h0001) begin fails++; $display("FAIL load_in_run_tick got=%h exp=0001", dig); end
    do_clr;
    checks++; if (dig !== 16'h0000 || run !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL clr_in_run got=%h run=%b done=%b exp=0000 0 0", dig, run, done);
    end
    do_start;
    cyc(6);
    checks++; if (dig !== 16'h0001) begin fails++; $display("FAIL pre_reset got=%h exp=0001", dig); end
    rst_n = 1'b0;
    cyc(1);
    checks++; if ({dig, run, held, wrap, done} !== 20'h0) begin
      fails++; $display("FAIL reset_mid_run got=%h/%b%b%b%b exp=0000/0000", dig, run, held, wrap, done);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_wrap_up;
    test_countdown_done;
    test_wrap_down;
    test_lap;
    test_stop_resume;
    test_clr_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
